// File: rtl/controlador_reproducao_pkg.sv
// -----------------------------------------------------------------------------
// controlador_reproducao_pkg
// Shared definitions for the playback sequencer:
//   estado_t     - FSM state encodings
//   cmd_t        - pending-command IDs (CMD_NONE..CMD_VOLTA_10S)
//   SEEK_10/30   - seek magnitudes in seconds (signed, 9 bits)
//   arbitra()    - fixed-priority pick among same-cycle button edges
//   seek_de()    - signed seek amount for a seek command
// -----------------------------------------------------------------------------
package controlador_reproducao_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PLAY,
      ST_FETCH,
      ST_CHECK,
      ST_SEEK,
      ST_SWITCH
   } estado_t;

   typedef enum logic [2:0] {
      CMD_NONE,
      CMD_PROX,
      CMD_PREV,
      CMD_PASSA_30S,
      CMD_VOLTA_30S,
      CMD_PASSA_10S,
      CMD_VOLTA_10S
   } cmd_t;

   localparam logic signed [8:0] SEEK_10 = 9'sd10;
   localparam logic signed [8:0] SEEK_30 = 9'sd30;

   // Edge vector order: [5]=prox [4]=prev [3]=passa_30s [2]=volta_30s
   // [1]=passa_10s [0]=volta_10s. Highest set bit wins; the rest are lost.
   function automatic cmd_t arbitra(input logic [5:0] edges);
      if (edges[5])      return CMD_PROX;
      else if (edges[4]) return CMD_PREV;
      else if (edges[3]) return CMD_PASSA_30S;
      else if (edges[2]) return CMD_VOLTA_30S;
      else if (edges[1]) return CMD_PASSA_10S;
      else if (edges[0]) return CMD_VOLTA_10S;
      else               return CMD_NONE;
   endfunction

   function automatic logic signed [8:0] seek_de(input cmd_t cmd);
      case (cmd)
         CMD_PASSA_30S: return SEEK_30;
         CMD_VOLTA_30S: return -SEEK_30;
         CMD_PASSA_10S: return SEEK_10;
         CMD_VOLTA_10S: return -SEEK_10;
         default:       return 9'sd0;
      endcase
   endfunction

endpackage

// File: rtl/controlador_reproducao_if.sv
// -----------------------------------------------------------------------------
// controlador_reproducao_if
// Bundle between the user buttons / ROM_musicas datapath and the sequencer.
//   Buttons (levels)   : btn_play_pause, btn_prox, btn_prev,
//                        btn_passa_10s, btn_volta_10s, btn_passa_30s, btn_volta_30s
//   ROM                : rom_data[7:0]
//   Status / pulses    : playing, sample_tick, sample_out[7:0], sample_valid,
//                        cmd_seek, seek_amount[8:0] (signed), cmd_prox, cmd_prev,
//                        track_start, busy
// Modports: slave  = the sequencer (consumes buttons/ROM, drives commands)
//           master = the environment (drives buttons/ROM, observes commands)
// -----------------------------------------------------------------------------
interface controlador_reproducao_if;

   logic                btn_play_pause;
   logic                btn_prox;
   logic                btn_prev;
   logic                btn_passa_10s;
   logic                btn_volta_10s;
   logic                btn_passa_30s;
   logic                btn_volta_30s;
   logic [7:0]          rom_data;

   logic                playing;
   logic                sample_tick;
   logic [7:0]          sample_out;
   logic                sample_valid;
   logic                cmd_seek;
   logic signed [8:0]   seek_amount;
   logic                cmd_prox;
   logic                cmd_prev;
   logic                track_start;
   logic                busy;

   modport slave (
      input  btn_play_pause, btn_prox, btn_prev, btn_passa_10s, btn_volta_10s,
             btn_passa_30s, btn_volta_30s, rom_data,
      output playing, sample_tick, sample_out, sample_valid, cmd_seek,
             seek_amount, cmd_prox, cmd_prev, track_start, busy
   );

   modport master (
      output btn_play_pause, btn_prox, btn_prev, btn_passa_10s, btn_volta_10s,
             btn_passa_30s, btn_volta_30s, rom_data,
      input  playing, sample_tick, sample_out, sample_valid, cmd_seek,
             seek_amount, cmd_prox, cmd_prev, track_start, busy
   );

endinterface

// File: rtl/controlador_reproducao_detector_borda.sv
// -----------------------------------------------------------------------------
// detector_borda
// Registered rising-edge detector for one button level.
//   clk    in  system clock
//   reset  in  synchronous, active-low reset
//   btn_i  in  button level, synchronous to clk
//   edge_o out high in the first cycle btn_i is high (btn_i & ~history)
// History resets to 1 so a button held through reset never produces an edge.
// -----------------------------------------------------------------------------
module detector_borda (
   input  logic clk,
   input  logic reset,
   input  logic btn_i,
   output logic edge_o
);

   logic btn_q;

   // NOTE: sequential state uses non-blocking (<=) so every register samples
   // pre-edge values; blocking here would create order-dependent races.
   always_ff @(posedge clk) begin
      if (!reset) btn_q <= 1'b1;
      else        btn_q <= btn_i;
   end

   assign edge_o = btn_i & ~btn_q;

endmodule

// File: rtl/controlador_reproducao.sv
// -----------------------------------------------------------------------------
// controlador_reproducao
// Playback sequencer for the music player: turns button levels into
// single-cycle commands, arbitrates them through a 1-entry pending slot,
// paces ROM fetches with a prescaler and detects the end-of-track marker.
//   clk    in  system clock
//   reset  in  synchronous, active-low reset
//   bus    controlador_reproducao_if.slave (buttons, rom_data, commands, status)
// Parameters: CLK_DIV (PLAY cycles per sample tick), ROM_LAT (address-to-data
// latency), END_MARK (end-of-track ROM word).
// Build option: define AUTO_ADVANCE_EN to jump to the next track (and keep
// playing) on the end marker; by default the end marker rewinds and pauses.
// Command/sample pulses are decoded in the cycle the FSM takes the decision,
// so sample_out and seek_amount present their new value alongside the pulse.
// -----------------------------------------------------------------------------
module controlador_reproducao #(
   parameter int unsigned CLK_DIV  = 6250,
   parameter int unsigned ROM_LAT  = 1,
   parameter logic [7:0]  END_MARK = 8'hFF
) (
   input logic                     clk,
   input logic                     reset,
   controlador_reproducao_if.slave bus
);

   import controlador_reproducao_pkg::*;

   localparam int unsigned PRESC_W = $clog2(CLK_DIV + 1);
   localparam int unsigned WAIT_W  = $clog2(ROM_LAT + 2);

   localparam logic [PRESC_W-1:0] PRESC_TOP   = PRESC_W'(CLK_DIV - 1);
   localparam logic [WAIT_W-1:0]  WAIT_ROM    = WAIT_W'(ROM_LAT - 1);
   localparam logic [WAIT_W-1:0]  WAIT_SWITCH = WAIT_W'(ROM_LAT);

   // Edge vector: [6]=prox [5]=prev [4]=passa_30s [3]=volta_30s
   // [2]=passa_10s [1]=volta_10s [0]=play_pause
   logic [6:0] btn_vec;
   logic [6:0] edge_vec;

   assign btn_vec = {bus.btn_prox, bus.btn_prev, bus.btn_passa_30s,
                     bus.btn_volta_30s, bus.btn_passa_10s, bus.btn_volta_10s,
                     bus.btn_play_pause};

   for (genvar i = 0; i < 7; i++) begin : g_borda
      detector_borda u_borda (
         .clk    (clk),
         .reset  (reset),
         .btn_i  (btn_vec[i]),
         .edge_o (edge_vec[i])
      );
   end

   estado_t                 state_q,   state_d;
   cmd_t                    pend_q,    pend_d;
   logic [PRESC_W-1:0]      presc_q,   presc_d;
   logic [WAIT_W-1:0]       wait_q,    wait_d;
   logic                    playing_q, playing_d;
   logic [7:0]              sample_q,  sample_d;
   logic signed [8:0]       seek_q,    seek_d;

   logic tick_p, valid_p, seek_p, prox_p, prev_p, start_p;
   logic ocioso;

   assign ocioso = (state_q == ST_IDLE) || (state_q == ST_PLAY);

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= ST_IDLE;
         pend_q    <= CMD_NONE;
         presc_q   <= '0;
         wait_q    <= '0;
         playing_q <= 1'b0;
         sample_q  <= '0;
         seek_q    <= '0;
      end else begin
         state_q   <= state_d;
         pend_q    <= pend_d;
         presc_q   <= presc_d;
         wait_q    <= wait_d;
         playing_q <= playing_d;
         sample_q  <= sample_d;
         seek_q    <= seek_d;
      end
   end

   // NOTE: every signal written below gets a default first, so no path
   // through the block leaves it unassigned and no latch is inferred.
   always_comb begin
      state_d   = state_q;
      pend_d    = pend_q;
      presc_d   = presc_q;
      wait_d    = wait_q;
      playing_d = playing_q;
      sample_d  = sample_q;
      seek_d    = seek_q;
      tick_p    = 1'b0;
      valid_p   = 1'b0;
      seek_p    = 1'b0;
      prox_p    = 1'b0;
      prev_p    = 1'b0;
      start_p   = 1'b0;

      // While reset is low nothing is issued; registers clear at the edge.
      if (reset) begin
         if (edge_vec[0]) playing_d = ~playing_q;

         // Slot accepts a new winner only when empty; otherwise edges are lost.
         if (pend_q == CMD_NONE) pend_d = arbitra(edge_vec[6:1]);

         if (ocioso && (pend_q != CMD_NONE)) begin
            // Dispatch takes the cycle, so PLAY neither counts nor ticks here.
            pend_d = CMD_NONE;
            case (pend_q)
               CMD_PROX, CMD_PREV: begin
                  prox_p  = (pend_q == CMD_PROX);
                  prev_p  = (pend_q == CMD_PREV);
                  start_p = 1'b1;
                  presc_d = '0;
                  wait_d  = WAIT_SWITCH;
                  state_d = ST_SWITCH;
               end
               default: begin
                  seek_p  = 1'b1;
                  seek_d  = seek_de(pend_q);
                  wait_d  = WAIT_ROM;
                  state_d = ST_SEEK;
               end
            endcase
         end else begin
            case (state_q)
               ST_IDLE: begin
                  if (playing_q) state_d = ST_PLAY;
               end
               ST_PLAY: begin
                  // Pause keeps the prescaler so resume continues mid-count.
                  if (!playing_q) begin
                     state_d = ST_IDLE;
                  end else if (presc_q == PRESC_TOP) begin
                     presc_d = '0;
                     tick_p  = 1'b1;
                     wait_d  = WAIT_ROM;
                     state_d = ST_FETCH;
                  end else begin
                     presc_d = presc_q + 1'b1;
                  end
               end
               ST_FETCH: begin
                  if (wait_q == '0) state_d = ST_CHECK;
                  else              wait_d  = wait_q - 1'b1;
               end
               ST_CHECK: begin
                  if (bus.rom_data == END_MARK) begin
                     start_p = 1'b1;
                     presc_d = '0;
                     wait_d  = WAIT_SWITCH;
                     state_d = ST_SWITCH;
`ifdef AUTO_ADVANCE_EN
                     prox_p  = 1'b1;
`else
                     // A same-cycle play_pause toggle still takes precedence.
                     if (!edge_vec[0]) playing_d = 1'b0;
`endif
                  end else begin
                     valid_p  = 1'b1;
                     sample_d = bus.rom_data;
                     state_d  = playing_q ? ST_PLAY : ST_IDLE;
                  end
               end
               ST_SEEK, ST_SWITCH: begin
                  if (wait_q == '0) state_d = playing_q ? ST_PLAY : ST_IDLE;
                  else              wait_d  = wait_q - 1'b1;
               end
               default: state_d = ST_IDLE;
            endcase
         end
      end
   end

   assign bus.playing      = playing_q;
   assign bus.sample_tick  = tick_p;
   assign bus.sample_valid = valid_p;
   assign bus.sample_out   = sample_d;
   assign bus.cmd_seek     = seek_p;
   assign bus.seek_amount  = seek_d;
   assign bus.cmd_prox     = prox_p;
   assign bus.cmd_prev     = prev_p;
   assign bus.track_start  = start_p;
   assign bus.busy         = !ocioso || (pend_q != CMD_NONE);

endmodule
